// File: rtl/branch_cc_if.sv
// Bundle between the EX/ID pipeline stages and the branch/condition-code unit.
// The master drives ALU flags and branch requests; the slave returns flags and flush control.
interface branch_cc_if #(
    parameter int CNT_W = 8
);
    logic             stall;
    logic             vld_EX;
    logic             upd_z;
    logic             upd_v;
    logic             upd_n;
    logic             zr;
    logic             ov;
    logic             neg;
    logic             br_ID;
    logic [2:0]       cc_ID;
    logic             flg_z;
    logic             flg_v;
    logic             flg_n;
    logic             br_taken;
    logic             flush_req;
    logic [CNT_W-1:0] ov_cnt;

    modport master (
        output stall, vld_EX, upd_z, upd_v, upd_n, zr, ov, neg, br_ID, cc_ID,
        input  flg_z, flg_v, flg_n, br_taken, flush_req, ov_cnt
    );

    modport slave (
        input  stall, vld_EX, upd_z, upd_v, upd_n, zr, ov, neg, br_ID, cc_ID,
        output flg_z, flg_v, flg_n, br_taken, flush_req, ov_cnt
    );
endinterface

// File: rtl/branch_cc_unit.sv
// Condition-code register with same-cycle EX->ID flag bypass, branch resolution,
// multi-cycle flush sequencing and a saturating overflow-event counter.
module branch_cc_unit #(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    branch_cc_if.slave  bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    logic       adv;
    logic [2:0] upd;
    logic [2:0] alu;
    logic [2:0] flg_reg;
    logic [2:0] eff;
    logic       cond;
    logic       take;

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic             br_taken_reg;
    logic             flush_req_reg;
    logic [CNT_W-1:0] ov_cnt_reg;

    assign adv = ~bus.stall;
    // Flag vectors are ordered {Z, V, N}.
    assign upd = {bus.upd_z, bus.upd_v, bus.upd_n};
    assign alu = {bus.zr, bus.ov, bus.neg};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            assign eff[gi] = (bus.vld_EX & upd[gi]) ? alu[gi] : flg_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    flg_reg[gi] <= 1'b0;
                end else if (adv && bus.vld_EX && upd[gi]) begin
                    flg_reg[gi] <= alu[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        cond = 1'b0;
        case (bus.cc_ID)
            3'b000:  cond = ~eff[2];
            3'b001:  cond = eff[2];
            3'b010:  cond = ~eff[2] & ~eff[0];
            3'b011:  cond = eff[0];
            3'b100:  cond = eff[2] | ~eff[0];
            3'b101:  cond = eff[2] | eff[0];
            3'b110:  cond = eff[1];
            default: cond = 1'b1;
        endcase
    end

    // Branches arriving while a flush is in progress are themselves being flushed.
    assign take = adv & bus.br_ID & cond & (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            br_taken_reg  <= 1'b0;
            flush_req_reg <= 1'b0;
        end else if (adv) begin
            case (state_reg)
                IDLE: begin
                    br_taken_reg  <= take;
                    flush_req_reg <= take;
                    if (take) begin
                        state_reg <= FLUSH;
                        cnt_reg   <= 3'(FLUSH_CYC - 1);
                    end
                end
                FLUSH: begin
                    br_taken_reg <= 1'b0;
                    if (cnt_reg == 3'd0) begin
                        state_reg     <= IDLE;
                        flush_req_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_cnt_reg <= '0;
        end else if (adv && bus.vld_EX && bus.upd_v && bus.ov && (ov_cnt_reg != '1)) begin
            ov_cnt_reg <= ov_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.flg_z     = flg_reg[2];
    assign bus.flg_v     = flg_reg[1];
    assign bus.flg_n     = flg_reg[0];
    assign bus.br_taken  = br_taken_reg;
    assign bus.flush_req = flush_req_reg;
    assign bus.ov_cnt    = ov_cnt_reg;
endmodule
